// File: rtl/ct_biu_ar_slice.sv
// AR channel slice between the BIU request arbiter and the external AR port.
// A 2-entry skid buffer gives a registered ready, and an outstanding-read counter throttles issue.
module ct_biu_ar_slice #(
    parameter int PLD_W     = 71,
    parameter int MAX_OUTST = 8,
    parameter int CNT_W     = 4
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             s_arvalid,
    input  logic [PLD_W-1:0] s_arpld,
    output logic             s_arready,
    output logic             m_arvalid,
    output logic [PLD_W-1:0] m_arpld,
    input  logic             m_arready,
    input  logic             r_last_hs,
    output logic [CNT_W-1:0] outst_cnt,
    output logic             ar_idle,
    output logic             outst_err
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

    state_t           state, state_nxt;
    logic [PLD_W-1:0] head, skid;
    logic             push, pop, credit;
    logic             head_ld, head_from_skid, skid_ld;

    assign push   = s_arvalid && s_arready;
    assign credit = (outst_cnt < MAX_C);
    assign pop    = m_arvalid && m_arready;

    // state register
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) state <= EMPTY;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL:  if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // output / datapath-enable logic; m_arvalid depends on flops only
    always_comb begin
        m_arvalid      = (state != EMPTY) && credit;
        ar_idle        = (state == EMPTY) && (outst_cnt == '0);
        head_ld        = 1'b0;
        head_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state)
            EMPTY: head_ld = push;
            ONE: begin
                head_ld = push && pop;
                skid_ld = push && !pop;
            end
            FULL: begin
                head_ld        = pop;
                head_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    // ready is registered so the arbiter never sees a combinational path from m_arready
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) s_arready <= 1'b0;
        else        s_arready <= (state_nxt != FULL);
    end

    always_ff @(posedge forever_cpuclk) begin
        if (head_ld) head <= head_from_skid ? skid : s_arpld;
        if (skid_ld) skid <= s_arpld;
    end

    assign m_arpld = head;

    // pop already implies credit, so the counter cannot pass MAX_OUTST
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            outst_cnt <= '0;
            outst_err <= 1'b0;
        end else begin
            if (pop && !r_last_hs) begin
                outst_cnt <= outst_cnt + CNT_W'(1);
            end else if (r_last_hs && !pop) begin
                if (outst_cnt == '0) outst_err <= 1'b1;
                else                 outst_cnt <= outst_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ct_biu_ar_slice.sv
// Bench for ct_biu_ar_slice: directed stimulus, a payload scoreboard fed on accept
// and drained by an independent monitor on every AR handshake.
module tb_ct_biu_ar_slice;

    localparam int PLD_W     = 71;
    localparam int MAX_OUTST = 8;
    localparam int CNT_W     = 4;

    logic             forever_cpuclk = 1'b0;
    logic             cpurst = 1'b1;
    logic             s_arvalid = 1'b0;
    logic [PLD_W-1:0] s_arpld = '0;
    logic             s_arready;
    logic             m_arvalid;
    logic [PLD_W-1:0] m_arpld;
    logic             m_arready = 1'b0;
    logic             r_last_hs = 1'b0;
    logic [CNT_W-1:0] outst_cnt;
    logic             ar_idle;
    logic             outst_err;

    ct_biu_ar_slice #(.PLD_W(PLD_W), .MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) dut (
        .forever_cpuclk(forever_cpuclk), .cpurst(cpurst),
        .s_arvalid(s_arvalid), .s_arpld(s_arpld), .s_arready(s_arready),
        .m_arvalid(m_arvalid), .m_arpld(m_arpld), .m_arready(m_arready),
        .r_last_hs(r_last_hs), .outst_cnt(outst_cnt), .ar_idle(ar_idle),
        .outst_err(outst_err)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    int               checks = 0;
    int               errors = 0;
    int               pop_cnt = 0;
    logic [PLD_W-1:0] exp_q[$];
    logic             accepted;
    logic             hold = 1'b0;
    logic [PLD_W-1:0] held;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {aruser..arburst high part, arsize, arlen, arid, araddr}; hi covers the upper 26 bits
    function automatic logic [PLD_W-1:0] mk(input logic [39:0] addr, input logic [4:0] id,
                                            input logic [25:0] hi);
        return {hi, id, addr};
    endfunction

    // inputs change 1 time unit after the edge; accept is observed at the negedge before it
    task automatic step();
        @(negedge forever_cpuclk);
        accepted = !cpurst && s_arvalid && s_arready;
        if (accepted) exp_q.push_back(s_arpld);
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_one(input logic [PLD_W-1:0] p);
        s_arvalid = 1'b1;
        s_arpld   = p;
        accepted  = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) step();
        if (!accepted) chk("push_timeout", 0, 1);
    endtask

    // monitor: payload order on AR handshakes, plus valid/payload stability while stalled
    always @(negedge forever_cpuclk) begin
        if (cpurst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stall_valid", m_arvalid, 1'b1);
                chk("stall_pld", m_arpld, held);
            end
            if (m_arvalid && m_arready) begin
                pop_cnt++;
                if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
                else chk("pop_pld", m_arpld, exp_q.pop_front());
            end
            hold = m_arvalid && !m_arready;
            held = m_arpld;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [PLD_W-1:0] pa, pb, pd, pe;
    int base;

    initial begin
        pa = mk(40'h00_8000_0040, 5'h10, 26'h0000_010);
        pb = mk(40'hA5_1234_5678, 5'h03, 26'h3FF_FFFF);
        pd = mk(40'h11_2222_3330, 5'h1F, 26'h155_5555);
        pe = mk(40'hFF_EEEE_DDC0, 5'h0A, 26'h2AA_AAAA);

        // reset state
        steps(2);
        chk("rst_ready", s_arready, 1'b0);
        chk("rst_valid", m_arvalid, 1'b0);
        chk("rst_idle", ar_idle, 1'b1);
        chk("rst_cnt", outst_cnt, 0);
        chk("rst_err", outst_err, 1'b0);
        cpurst = 1'b0;
        step();
        chk("rel_ready", s_arready, 1'b1);

        // single request
        m_arready = 1'b1;
        push_one(pa);
        s_arvalid = 1'b0;
        chk("single_valid", m_arvalid, 1'b1);
        chk("single_pld", m_arpld, pa);
        step();
        chk("single_cnt1", outst_cnt, 1);
        chk("single_busy", ar_idle, 1'b0);
        r_last_hs = 1'b1;
        step();
        r_last_hs = 1'b0;
        chk("single_cnt0", outst_cnt, 0);
        chk("single_idle", ar_idle, 1'b1);

        // backpressure into the skid entry
        m_arready = 1'b0;
        push_one(pa);
        push_one(pb);
        s_arvalid = 1'b0;
        chk("skid_ready0", s_arready, 1'b0);
        chk("skid_headA", m_arpld, pa);
        step();
        chk("skid_ready0b", s_arready, 1'b0);
        m_arready = 1'b1;
        step();
        chk("skid_headB", m_arpld, pb);
        chk("skid_validB", m_arvalid, 1'b1);
        chk("skid_ready1", s_arready, 1'b1);
        step();
        chk("skid_cnt2", outst_cnt, 2);
        r_last_hs = 1'b1;
        steps(2);
        r_last_hs = 1'b0;
        chk("skid_drain", outst_cnt, 0);

        // credit limit: 10 requests, only MAX_OUTST issue
        base = pop_cnt;
        for (int i = 0; i < 10; i++)
            push_one(mk(40'h40_0000_0000 + 40'(i * 64), 5'(i), 26'(i * 26'h01_0101)));
        s_arvalid = 1'b0;
        steps(2);
        chk("credit_pops", pop_cnt - base, 8);
        chk("credit_cnt", outst_cnt, 8);
        chk("credit_valid", m_arvalid, 1'b0);
        chk("credit_full", s_arready, 1'b0);
        r_last_hs = 1'b1;
        step();
        r_last_hs = 1'b0;
        chk("credit_cnt7", outst_cnt, 7);
        chk("credit_valid1", m_arvalid, 1'b1);
        step();
        chk("credit_pops9", pop_cnt - base, 9);
        chk("credit_cnt8", outst_cnt, 8);
        chk("credit_ready", s_arready, 1'b1);
        step();
        chk("credit_pops9b", pop_cnt - base, 9);
        chk("credit_valid0", m_arvalid, 1'b0);

        // pop and r_last_hs together with outst_cnt=3
        m_arready = 1'b0;
        r_last_hs = 1'b1;
        steps(5);
        chk("simul_cnt3pre", outst_cnt, 3);
        m_arready = 1'b1;
        step();
        r_last_hs = 1'b0;
        m_arready = 1'b0;
        chk("simul_cnt3", outst_cnt, 3);
        chk("simul_empty", m_arvalid, 1'b0);

        // push and pop together in ONE
        push_one(pd);
        m_arready = 1'b1;
        push_one(pe);
        s_arvalid = 1'b0;
        chk("pp_headE", m_arpld, pe);
        chk("pp_valid", m_arvalid, 1'b1);
        chk("pp_ready", s_arready, 1'b1);
        chk("pp_cnt4", outst_cnt, 4);
        step();
        chk("pp_cnt5", outst_cnt, 5);
        r_last_hs = 1'b1;
        steps(5);
        r_last_hs = 1'b0;
        chk("pp_drain", outst_cnt, 0);
        chk("pp_noerr", outst_err, 1'b0);

        // underflow is sticky
        r_last_hs = 1'b1;
        step();
        r_last_hs = 1'b0;
        chk("uf_cnt", outst_cnt, 0);
        chk("uf_err", outst_err, 1'b1);
        steps(3);
        chk("uf_sticky", outst_err, 1'b1);

        // reset while FULL with outst_cnt=5
        for (int i = 0; i < 5; i++) push_one(mk(40'h0C_0000_1000 + 40'(i * 8), 5'(i + 7), 26'h0ABCDEF));
        s_arvalid = 1'b0;
        steps(2);
        chk("mr_cnt5", outst_cnt, 5);
        m_arready = 1'b0;
        push_one(pd);
        push_one(pe);
        s_arvalid = 1'b0;
        chk("mr_full", s_arready, 1'b0);
        cpurst = 1'b1;
        exp_q.delete();
        step();
        chk("mr_valid", m_arvalid, 1'b0);
        chk("mr_cnt", outst_cnt, 0);
        chk("mr_idle", ar_idle, 1'b1);
        chk("mr_ready", s_arready, 1'b0);
        chk("mr_err", outst_err, 1'b0);
        cpurst = 1'b0;
        step();
        chk("mr_rel_ready", s_arready, 1'b1);

        m_arready = 1'b1;
        push_one(pb);
        s_arvalid = 1'b0;
        steps(2);
        chk("post_cnt", outst_cnt, 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ct_biu_ar_slice.md
Name: ct_biu_ar_slice

Overview:
- Read-address channel stage directly downstream of the BIU request arbiter, between the arbiter's AR output and the external AR port.
- Holds the arbitrated AR request (all fields packed into one payload) in a 2-entry skid buffer, so the ready signal returned to the arbiter is registered.
- Limits in-flight reads with an outstanding counter: it increments on each AR handshake and decrements on each last-beat R handshake.
- Reports idle status to the BIU clock gating and low-power logic.

Parameters:
- PLD_W, 71, packed AR payload width. Fields: {aruser[2:0], arbar[1:0], ardomain[1:0], arsnoop[3:0], arprot[2:0], arcache[3:0], arlock, arburst[1:0], arsize[2:0], arlen[1:0], arid[4:0], araddr[39:0]}.
- MAX_OUTST, 8, maximum number of outstanding read transactions.
- CNT_W, 4, counter width. Must satisfy 2^CNT_W > MAX_OUTST.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  synchronous active-high reset.
- s_arvalid  in  1  request valid from arbiter.
- s_arpld  in  PLD_W  packed request payload from arbiter.
- s_arready  out  1  registered ready to arbiter.
- m_arvalid  out  1  AR valid to bus.
- m_arpld  out  PLD_W  AR payload to bus.
- m_arready  in  1  AR ready from bus.
- r_last_hs  in  1  one R beat with rlast accepted this cycle (rvalid && rready && rlast).
- outst_cnt  out  CNT_W  current outstanding read count.
- ar_idle  out  1  buffer empty and outst_cnt==0.
- outst_err  out  1  sticky error: r_last_hs seen with outst_cnt==0.

Behaviour:
- Definitions:
  - push = s_arvalid && s_arready.
  - pop = m_arvalid && m_arready.
  - credit = (outst_cnt < MAX_OUTST).
- Storage: head register (drives m_arpld) and skid register. State is encoded as EMPTY / ONE / FULL.
- m_arvalid = (state != EMPTY) && credit. This output is combinational from flops only.
- AXI stability: once m_arvalid is high, it and m_arpld stay constant until pop.
  - This holds by construction: outst_cnt only rises on pop, so credit cannot fall while m_arvalid is high.
- s_arready is registered: next value = !(next_state == FULL).
- State transitions:
  - EMPTY:
    - push → ONE, head <= s_arpld.
  - ONE:
    - push && !pop → FULL, skid <= s_arpld.
    - push && pop → ONE, head <= s_arpld.
    - pop && !push → EMPTY.
    - Otherwise hold.
  - FULL (s_arready=0, so push is impossible):
    - pop → ONE, head <= skid.
    - Otherwise hold.
- Latency: a request pushed in cycle N appears on m_arvalid in cycle N+1 (if credit). Sustained throughput is one request per cycle.
- Counter:
  - pop && !r_last_hs → +1.
  - r_last_hs && !pop → -1.
  - Both → unchanged.
  - Never exceeds MAX_OUTST, because pop requires credit.
- Underflow: r_last_hs with outst_cnt==0 leaves outst_cnt at 0 and sets outst_err. The error flag clears only on reset.
- ar_idle = (state==EMPTY) && (outst_cnt==0). Registered-equivalent (derived from flops).
- Reset, synchronous (including mid-operation):
  - state=EMPTY, head and skid contents don't-care.
  - outst_cnt=0, outst_err=0.
  - s_arready=0 during reset, 1 in the first cycle after cpurst deasserts.
  - m_arvalid=0, ar_idle=1.
  - An in-flight request is discarded. The arbiter is reset concurrently.
- Payload is passed through unmodified, with no field decode. Head and skid registers load only on the enable conditions above.

Test Plan:
- Single request:
  - Stimulus: after reset, push payload A (araddr=40'h00_8000_0040, arid=5'h10) in cycle 2; m_arready=1.
  - Required response: m_arvalid=1 with payload A in cycle 3; outst_cnt=1 in cycle 4; r_last_hs in cycle 6 → outst_cnt=0 and ar_idle=1 in cycle 7.
- Backpressure / skid:
  - Stimulus: m_arready=0; push A in cycle 1 and B in cycle 2.
  - Required response: s_arready=0 from cycle 3; m_arpld stays A; raising m_arready in cycle 5 gives pop A in 5, B on m_arpld in cycle 6, s_arready=1 in cycle 6; order is A then B with no loss or duplication.
- Credit limit:
  - Stimulus: MAX_OUTST=8, m_arready=1, 10 back-to-back pushes, no r_last_hs.
  - Required response: exactly 8 pops; outst_cnt=8; m_arvalid=0; s_arready=0 once FULL. One r_last_hs → exactly one further pop next cycle, outst_cnt returns to 8.
- Simultaneous events:
  - Stimulus: pop and r_last_hs in the same cycle with outst_cnt=3.
  - Required response: outst_cnt stays 3.
  - Stimulus: push and pop in the same cycle in state ONE.
  - Required response: state stays ONE, head holds the new payload.
- Underflow:
  - Stimulus: r_last_hs with outst_cnt=0.
  - Required response: outst_cnt=0, outst_err=1 next cycle and sticky until reset.
- Reset mid-operation:
  - Stimulus: assert cpurst while FULL with outst_cnt=5.
  - Required response: next cycle m_arvalid=0, outst_cnt=0, ar_idle=1, s_arready=0; s_arready=1 in the first cycle after release.
